// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake into a small FIFO, LSB-first
// serialisation with a runtime-programmable bit period.
module uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [23:0] DEFAULT_DIV = 24'd10416
) (
    input  logic        uart_clock,
    input  logic        uart_reset,
    input  logic [7:0]  uart_d_in,
    input  logic        uart_valid_in,
    output logic        uart_ready,
    input  logic [23:0] baud_div,
    output logic        uart_tx_out,
    output logic        uart_busy,
    output logic        uart_done
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // 0 selects the default period; 1 is raised to 2 so every bit spans at least two clocks
    function automatic logic [23:0] eff_div(input logic [23:0] d);
        logic [23:0] r;
        if (d == 24'd0) begin
            r = DEFAULT_DIV;
        end else if (d == 24'd1) begin
            r = 24'd2;
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    state_t        state_r;
    state_t        state_s;
    logic [9:0]    shreg_r;
    logic [9:0]    shreg_s;
    logic [3:0]    bit_idx_r;
    logic [3:0]    bit_idx_s;
    logic [23:0]   clk_cnt_r;
    logic [23:0]   clk_cnt_s;
    logic [23:0]   div_q_r;
    logic [23:0]   div_q_s;
    logic          tx_r;
    logic          tx_s;
    logic          done_r;
    logic          done_s;

    assign uart_ready  = (count_r != FULL_COUNT);
    assign uart_busy   = (count_r != CNT_ZERO) || (state_r != ST_IDLE);
    assign uart_tx_out = tx_r;
    assign uart_done   = done_r;
    assign push_s      = uart_valid_in && uart_ready;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge uart_clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= uart_d_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shifter, counters and registered line/done outputs
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            shreg_r   <= 10'h3FF;
            bit_idx_r <= 4'd0;
            clk_cnt_r <= 24'd0;
            div_q_r   <= 24'd0;
            tx_r      <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            shreg_r   <= shreg_s;
            bit_idx_r <= bit_idx_s;
            clk_cnt_r <= clk_cnt_s;
            div_q_r   <= div_q_s;
            tx_r      <= tx_s;
            done_r    <= done_s;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_idx_s = bit_idx_r;
        clk_cnt_s = clk_cnt_r;
        div_q_s   = div_q_r;
        tx_s      = tx_r;
        done_s    = 1'b0;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (count_r != CNT_ZERO) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pop_s     = 1'b1;
                shreg_s   = {1'b1, fifo_mem_r[rd_ptr_r], 1'b0};
                div_q_s   = eff_div(baud_div);
                bit_idx_s = 4'd0;
                clk_cnt_s = 24'd0;
                tx_s      = 1'b0;
                state_s   = ST_SEND;
            end
            ST_SEND: begin
                if (clk_cnt_r == (div_q_r - 24'd1)) begin
                    clk_cnt_s = 24'd0;
                    if (bit_idx_r == 4'd9) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                        tx_s    = 1'b1;
                    end else begin
                        bit_idx_s = bit_idx_r + 4'd1;
                        shreg_s   = {1'b1, shreg_r[9:1]};
                        tx_s      = shreg_r[1];
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 24'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

endmodule
